// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, exception codes and bus layouts for the
// execute -> memory -> write-back pipeline boundary.
//   es_to_ms_bus_t    : 129-bit bus from execute into the memory stage
//   ms_to_ws_bus_t    : 124-bit bus from the memory stage to write-back
//   ms_fwd_blk_bus_t  :  42-bit forwarding / load-use blocking bus to decode
package mem_stage_pkg;

    localparam int unsigned ES_TO_MS_BUS_WD   = 129;
    localparam int unsigned MS_TO_WS_BUS_WD   = 124;
    localparam int unsigned MS_FWD_BLK_BUS_WD = 42;

    // CP0 Cause.ExcCode values carried on the excode field
    localparam logic [4:0] EX_INT  = 5'h00;
    localparam logic [4:0] EX_ADEL = 5'h04;
    localparam logic [4:0] EX_ADES = 5'h05;
    localparam logic [4:0] EX_SYS  = 5'h08;
    localparam logic [4:0] EX_BP   = 5'h09;
    localparam logic [4:0] EX_RI   = 5'h0a;
    localparam logic [4:0] EX_OV   = 5'h0c;

    typedef struct packed {
        logic [4:0]  excode;
        logic [31:0] badvaddr;
        logic [7:0]  cp0_addr;
        logic        ex;
        logic        bd;
        logic        eret;
        logic        syscall;
        logic        mfc0;
        logic        mtc0;
        logic        lb;
        logic        lbu;
        logic        lh;
        logic        lhu;
        logic        lw;
        logic        lwl;
        logic        lwr;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] exe_result;
        logic [31:0] pc;
    } es_to_ms_bus_t;

    typedef struct packed {
        logic [4:0]  excode;
        logic [31:0] badvaddr;
        logic [7:0]  cp0_addr;
        logic        ex;
        logic        bd;
        logic        eret;
        logic        syscall;
        logic        mfc0;
        logic        mtc0;
        logic [3:0]  rf_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_bus_t;

    typedef struct packed {
        logic [3:0]  fwd_valid;
        logic [4:0]  rf_dest;
        logic [31:0] rf_data;
        logic        blk_valid;
    } ms_fwd_blk_bus_t;

    // Read-data capture state: EMPTY uses live SRAM data, HELD uses the buffer
    typedef enum logic {
        RD_EMPTY = 1'b0,
        RD_HELD  = 1'b1
    } rdata_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: valid/allowin handshake plus payload bus between two
// pipeline stages.
//   valid   : producer offers a payload
//   allowin : consumer can accept this cycle
//   bus     : payload, WD bits
interface mem_stage_if #(
    parameter int unsigned WD = 1
);
    logic          valid;
    logic          allowin;
    logic [WD-1:0] bus;

    modport master (output valid, output bus, input allowin);
    modport slave  (input valid, input bus, output allowin);
endinterface

// File: rtl/mem_stage_load_align.sv
// mem_stage_load_align: extracts and aligns load data from a 32-bit read word.
//   lb..lwr : one-hot load type
//   a       : byte address offset
//   rdata   : effective read data
//   result  : aligned / extended load result (0 when no load flag set)
//   rf_we   : per-byte register write enables for the load
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic        lb,
    input  logic        lbu,
    input  logic        lh,
    input  logic        lhu,
    input  logic        lw,
    input  logic        lwl,
    input  logic        lwr,
    input  logic [1:0]  a,
    input  logic [31:0] rdata,
    output logic [31:0] result,
    output logic [3:0]  rf_we
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{a, 3'b000} +: 8];
        half_sel = a[1] ? rdata[31:16] : rdata[15:0];
        result   = '0;
        rf_we    = '0;
        if (lb | lbu) begin
            result = {{24{lb & byte_sel[7]}}, byte_sel};
            rf_we  = 4'b1111;
        end else if (lh | lhu) begin
            result = {{16{lh & half_sel[15]}}, half_sel};
            rf_we  = 4'b1111;
        end else if (lw) begin
            result = rdata;
            rf_we  = 4'b1111;
        end else if (lwl) begin
            // Low bytes of memory land in the high bytes of the register
            case (a)
                2'd0:    begin result = {rdata[7:0],  24'h0}; rf_we = 4'b1000; end
                2'd1:    begin result = {rdata[15:0], 16'h0}; rf_we = 4'b1100; end
                2'd2:    begin result = {rdata[23:0], 8'h0};  rf_we = 4'b1110; end
                default: begin result = rdata;                rf_we = 4'b1111; end
            endcase
        end else if (lwr) begin
            // High bytes of memory land in the low bytes of the register
            case (a)
                2'd0:    begin result = rdata;                rf_we = 4'b1111; end
                2'd1:    begin result = {8'h0,  rdata[31:8]};  rf_we = 4'b0111; end
                2'd2:    begin result = {16'h0, rdata[31:16]}; rf_we = 4'b0011; end
                default: begin result = {24'h0, rdata[31:24]}; rf_we = 4'b0001; end
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage between execute and write-back.
//   clk, reset       : clock, synchronous active-high reset
//   es_ms            : execute -> memory handshake and bus (allowin = ms_allowin)
//   ms_ws            : memory -> write-back handshake and bus (allowin = ws_allowin)
//   data_sram_rdata  : SRAM read data, valid the first cycle an op sits here
//   ms_fwd_blk_bus   : forwarding data and MFC0 blocking toward decode
//   ms_inst_mfc0_o   : valid MFC0 in this stage
//   ms_ex            : valid excepting instruction in this stage
//   ws_ex, eret_flush: write-back flush requests
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    mem_stage_if.slave                   es_ms,
    mem_stage_if.master                  ms_ws,
    input  logic [31:0]                  data_sram_rdata,
    output logic [MS_FWD_BLK_BUS_WD-1:0] ms_fwd_blk_bus,
    output logic                         ms_inst_mfc0_o,
    output logic                         ms_ex,
    input  logic                         ws_ex,
    input  logic                         eret_flush
);

    logic            ms_valid;
    logic            ms_ready_go;
    logic            ms_allowin;
    logic            flush_c;
    es_to_ms_bus_t   ms_bus;
    rdata_state_e    state;
    rdata_state_e    state_nxt;
    logic            capture_c;
    logic [31:0]     rdata_buf;
    logic [31:0]     rdata_c;
    logic [31:0]     align_result;
    logic [3:0]      align_we;
    logic [31:0]     final_result_c;
    logic [3:0]      rf_we_c;
    ms_to_ws_bus_t   ws_bus_c;
    ms_fwd_blk_bus_t fwd_c;

    assign ms_ready_go   = 1'b1;
    assign ms_allowin    = !ms_valid || (ms_ready_go && ms_ws.allowin);
    assign es_ms.allowin = ms_allowin;
    assign flush_c       = ws_ex | eret_flush;

    // Stage valid bit
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_ms.valid;
        end
    end

    // Payload register
    always_ff @(posedge clk) begin
        if (es_ms.valid && ms_allowin) begin
            ms_bus <= es_to_ms_bus_t'(es_ms.bus);
        end
    end

    // Read-data capture state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RD_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // SRAM data only lasts one cycle; keep a copy while write-back stalls us
    always_ff @(posedge clk) begin
        if (capture_c) begin
            rdata_buf <= data_sram_rdata;
        end
    end

    // Read-data capture next state and effective read data
    always_comb begin
        state_nxt = state;
        capture_c = 1'b0;
        rdata_c   = data_sram_rdata;
        case (state)
            RD_EMPTY: begin
                if (ms_valid && !ms_ws.allowin) begin
                    capture_c = 1'b1;
                    state_nxt = RD_HELD;
                end
            end
            RD_HELD: begin
                rdata_c = rdata_buf;
                if (ms_ws.allowin || flush_c) begin
                    state_nxt = RD_EMPTY;
                end
            end
            default: state_nxt = RD_EMPTY;
        endcase
    end

    mem_stage_load_align u_load_align (
        .lb     (ms_bus.lb),
        .lbu    (ms_bus.lbu),
        .lh     (ms_bus.lh),
        .lhu    (ms_bus.lhu),
        .lw     (ms_bus.lw),
        .lwl    (ms_bus.lwl),
        .lwr    (ms_bus.lwr),
        .a      (ms_bus.exe_result[1:0]),
        .rdata  (rdata_c),
        .result (align_result),
        .rf_we  (align_we)
    );

    // Result select and write-enable gating; MFC0 data only exists in write-back
    always_comb begin
        final_result_c = ms_bus.res_from_mem ? align_result : ms_bus.exe_result;
        rf_we_c        = ms_bus.res_from_mem ? align_we : {4{ms_bus.gr_we}};
        if (ms_bus.ex || ms_bus.mfc0) begin
            rf_we_c = 4'b0000;
        end
    end

    // Write-back bus and forwarding bus assembly
    always_comb begin
        ws_bus_c              = '0;
        ws_bus_c.excode       = ms_bus.excode;
        ws_bus_c.badvaddr     = ms_bus.badvaddr;
        ws_bus_c.cp0_addr     = ms_bus.cp0_addr;
        ws_bus_c.ex           = ms_bus.ex;
        ws_bus_c.bd           = ms_bus.bd;
        ws_bus_c.eret         = ms_bus.eret;
        ws_bus_c.syscall      = ms_bus.syscall;
        ws_bus_c.mfc0         = ms_bus.mfc0;
        ws_bus_c.mtc0         = ms_bus.mtc0;
        ws_bus_c.rf_we        = rf_we_c;
        ws_bus_c.dest         = ms_bus.dest;
        ws_bus_c.final_result = final_result_c;
        ws_bus_c.pc           = ms_bus.pc;

        fwd_c           = '0;
        fwd_c.fwd_valid = rf_we_c & {4{ms_valid && !ms_bus.mfc0 && !flush_c}};
        fwd_c.rf_dest   = ms_bus.dest;
        fwd_c.rf_data   = final_result_c;
        fwd_c.blk_valid = ms_valid && ms_bus.mfc0 && !flush_c;
    end

    assign ms_ws.valid    = ms_valid && ms_ready_go && !flush_c;
    assign ms_ws.bus      = ws_bus_c;
    assign ms_fwd_blk_bus = fwd_c;
    assign ms_inst_mfc0_o = ms_valid && ms_bus.mfc0;
    assign ms_ex          = ms_valid && ms_bus.ex;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage. Directed scenarios plus a
// randomized run checked against a behavioural model of the stage.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic            clk;
    logic            reset;
    logic            es_valid;
    es_to_ms_bus_t   es_bus;
    logic            ws_allowin;
    logic [31:0]     data_sram_rdata;
    logic [MS_FWD_BLK_BUS_WD-1:0] ms_fwd_blk_bus;
    logic            ms_inst_mfc0_o;
    logic            ms_ex;
    logic            ws_ex;
    logic            eret_flush;
    ms_to_ws_bus_t   wb;
    ms_fwd_blk_bus_t fwd;

    int errors = 0;
    int checks = 0;

    mem_stage_if #(.WD(ES_TO_MS_BUS_WD)) es_ms ();
    mem_stage_if #(.WD(MS_TO_WS_BUS_WD)) ms_ws ();

    assign es_ms.valid   = es_valid;
    assign es_ms.bus     = es_bus;
    assign ms_ws.allowin = ws_allowin;
    assign wb            = ms_to_ws_bus_t'(ms_ws.bus);
    assign fwd           = ms_fwd_blk_bus_t'(ms_fwd_blk_bus);

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .es_ms           (es_ms),
        .ms_ws           (ms_ws),
        .data_sram_rdata (data_sram_rdata),
        .ms_fwd_blk_bus  (ms_fwd_blk_bus),
        .ms_inst_mfc0_o  (ms_inst_mfc0_o),
        .ms_ex           (ms_ex),
        .ws_ex           (ws_ex),
        .eret_flush      (eret_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // Reference: {rf_we, final_result} from the architectural load rules
    function automatic logic [35:0] model(input es_to_ms_bus_t e, input logic [31:0] rd);
        int a;
        logic [31:0] r;
        logic [3:0]  w;
        a = int'(e.exe_result[1:0]);
        r = e.exe_result;
        w = {4{e.gr_we}};
        if (e.lb || e.lbu) begin
            r = (rd >> (8 * a)) & 32'h0000_00ff;
            if (e.lb && r[7]) r = r | 32'hffff_ff00;
            w = 4'hf;
        end else if (e.lh || e.lhu) begin
            r = (rd >> (16 * (a / 2))) & 32'h0000_ffff;
            if (e.lh && r[15]) r = r | 32'hffff_0000;
            w = 4'hf;
        end else if (e.lw) begin
            r = rd;
            w = 4'hf;
        end else if (e.lwl) begin
            r = rd << (8 * (3 - a));
            w = 4'h0;
            for (int i = 0; i < 4; i++) if (i >= 3 - a) w[i] = 1'b1;
        end else if (e.lwr) begin
            r = rd >> (8 * a);
            w = 4'h0;
            for (int i = 0; i < 4; i++) if (i <= 3 - a) w[i] = 1'b1;
        end
        if (e.ex || e.mfc0) w = 4'h0;
        return {w, r};
    endfunction

    // Instruction of kind op: 0 alu, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6 lwl, 7 lwr, 8 mfc0, 9 mtc0
    function automatic es_to_ms_bus_t set_op(input es_to_ms_bus_t base, input int op);
        es_to_ms_bus_t e;
        e = base;
        {e.lb, e.lbu, e.lh, e.lhu, e.lw, e.lwl, e.lwr} = 7'b0;
        e.mfc0 = 1'b0;
        e.mtc0 = 1'b0;
        e.res_from_mem = (op >= 1 && op <= 7);
        case (op)
            1: e.lb  = 1'b1;
            2: e.lbu = 1'b1;
            3: e.lh  = 1'b1;
            4: e.lhu = 1'b1;
            5: e.lw  = 1'b1;
            6: e.lwl = 1'b1;
            7: e.lwr = 1'b1;
            8: e.mfc0 = 1'b1;
            9: e.mtc0 = 1'b1;
            default: ;
        endcase
        if (e.res_from_mem || op == 8) e.gr_we = 1'b1;
        if (op == 9) e.gr_we = 1'b0;
        return e;
    endfunction

    function automatic es_to_ms_bus_t rand_bus();
        es_to_ms_bus_t e;
        e = es_to_ms_bus_t'(ES_TO_MS_BUS_WD'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()}));
        e = set_op(e, $urandom_range(0, 9));
        e.ex = ($urandom_range(0, 9) == 0);
        return e;
    endfunction

    // Offer e for one accepting edge, then present rd and wa in its first MEM cycle
    task automatic issue(input es_to_ms_bus_t e, input logic [31:0] rd, input logic wa);
        es_valid = 1'b1;
        es_bus   = e;
        @(posedge clk);
        @(negedge clk);
        es_valid        = 1'b0;
        data_sram_rdata = rd;
        ws_allowin      = wa;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; es_valid = 1'b0; es_bus = '0; ws_allowin = 1'b1;
        data_sram_rdata = '0; ws_ex = 1'b0; eret_flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (ms_ws.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ms_ws.valid); end
        checks++; if (fwd.fwd_valid !== 4'h0) begin errors++; $display("FAIL reset_fwd got=%h exp=0", fwd.fwd_valid); end
        checks++; if (fwd.blk_valid !== 1'b0) begin errors++; $display("FAIL reset_blk got=%b exp=0", fwd.blk_valid); end
        checks++; if (ms_ex !== 1'b0) begin errors++; $display("FAIL reset_ms_ex got=%b exp=0", ms_ex); end
        checks++; if (ms_inst_mfc0_o !== 1'b0) begin errors++; $display("FAIL reset_mfc0 got=%b exp=0", ms_inst_mfc0_o); end
        checks++; if (es_ms.allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got=%b exp=1", es_ms.allowin); end
    endtask

    task automatic test_load_align();
        int          ops [4] = '{1, 2, 6, 7};
        logic [1:0]  offs[4] = '{2'd3, 2'd3, 2'd1, 2'd2};
        logic [31:0] rds [4] = '{32'h8012_3456, 32'h8012_3456, 32'haabb_ccdd, 32'haabb_ccdd};
        logic [31:0] res [4] = '{32'hffff_ff80, 32'h0000_0080, 32'hccdd_0000, 32'h0000_aabb};
        logic [3:0]  wes [4] = '{4'b1111, 4'b1111, 4'b1100, 4'b0011};
        es_to_ms_bus_t e;
        for (int i = 0; i < 4; i++) begin
            e = '0;
            e.dest = 5'd9;
            e.exe_result = {30'h0400_0000, offs[i]};
            e.pc = 32'hbfc0_0000 + 32'(i * 4);
            e = set_op(e, ops[i]);
            ws_allowin = 1'b1;
            issue(e, rds[i], 1'b1);
            checks++; if (ms_ws.valid !== 1'b1) begin errors++; $display("FAIL align%0d_valid got=%b exp=1", i, ms_ws.valid); end
            checks++; if (wb.final_result !== res[i]) begin errors++; $display("FAIL align%0d_result got=%h exp=%h", i, wb.final_result, res[i]); end
            checks++; if (wb.rf_we !== wes[i]) begin errors++; $display("FAIL align%0d_we got=%b exp=%b", i, wb.rf_we, wes[i]); end
            checks++; if (fwd.fwd_valid !== wes[i]) begin errors++; $display("FAIL align%0d_fwd got=%b exp=%b", i, fwd.fwd_valid, wes[i]); end
        end
    endtask

    task automatic test_stall();
        es_to_ms_bus_t e;
        e = '0;
        e.dest = 5'd4;
        e.exe_result = 32'h0000_1000;
        e = set_op(e, 5);
        ws_allowin = 1'b1;
        issue(e, 32'h1234_5678, 1'b0);
        checks++; if (es_ms.allowin !== 1'b0) begin errors++; $display("FAIL stall_allowin got=%b exp=0", es_ms.allowin); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            data_sram_rdata = 32'hdead_beef;
            ws_allowin = (k == 2);
            #1;
            checks++; if (ms_ws.valid !== 1'b1) begin errors++; $display("FAIL stall%0d_valid got=%b exp=1", k, ms_ws.valid); end
            checks++; if (wb.final_result !== 32'h1234_5678) begin errors++; $display("FAIL stall%0d_result got=%h exp=12345678", k, wb.final_result); end
        end
        // Reset while holding read data must drop the held copy
        ws_allowin = 1'b1;
        issue(e, 32'h1111_1111, 1'b0);
        @(posedge clk);
        @(negedge clk);
        data_sram_rdata = 32'hdead_beef;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (ms_ws.valid !== 1'b0) begin errors++; $display("FAIL held_reset_valid got=%b exp=0", ms_ws.valid); end
        issue(e, 32'h2222_2222, 1'b1);
        checks++; if (wb.final_result !== 32'h2222_2222) begin errors++; $display("FAIL held_reset_result got=%h exp=22222222", wb.final_result); end
    endtask

    task automatic test_exception();
        es_to_ms_bus_t e;
        e = '0;
        e.excode = EX_ADEL;
        e.badvaddr = 32'h0000_1001;
        e.cp0_addr = 8'h40;
        e.bd = 1'b1;
        e.dest = 5'd7;
        e.exe_result = 32'h0000_1001;
        e.pc = 32'hbfc0_0100;
        e = set_op(e, 5);
        e.ex = 1'b1;
        ws_allowin = 1'b1;
        issue(e, 32'h5555_aaaa, 1'b1);
        checks++; if (ms_ex !== 1'b1) begin errors++; $display("FAIL exc_ms_ex got=%b exp=1", ms_ex); end
        checks++; if (wb.rf_we !== 4'h0) begin errors++; $display("FAIL exc_we got=%b exp=0000", wb.rf_we); end
        checks++; if (fwd.fwd_valid !== 4'h0) begin errors++; $display("FAIL exc_fwd got=%b exp=0000", fwd.fwd_valid); end
        checks++; if ({wb.excode, wb.badvaddr, wb.cp0_addr, wb.ex, wb.bd, wb.pc} !== {EX_ADEL, 32'h0000_1001, 8'h40, 1'b1, 1'b1, 32'hbfc0_0100})
            begin errors++; $display("FAIL exc_fields got=%h/%h/%h/%b/%b/%h exp=04/00001001/40/1/1/bfc00100", wb.excode, wb.badvaddr, wb.cp0_addr, wb.ex, wb.bd, wb.pc); end
        checks++; if (ms_ws.valid !== 1'b1) begin errors++; $display("FAIL exc_valid got=%b exp=1", ms_ws.valid); end
    endtask

    task automatic test_flush();
        es_to_ms_bus_t e;
        e = '0;
        e.dest = 5'd5;
        e.exe_result = 32'h0000_1234;
        e.gr_we = 1'b1;
        ws_allowin = 1'b1;
        issue(e, 32'h0, 1'b1);
        checks++; if (ms_ws.valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got=%b exp=1", ms_ws.valid); end
        ws_ex = 1'b1;
        #1;
        checks++; if (ms_ws.valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", ms_ws.valid); end
        checks++; if (fwd.fwd_valid !== 4'h0) begin errors++; $display("FAIL flush_fwd got=%b exp=0000", fwd.fwd_valid); end
        @(posedge clk);
        @(negedge clk);
        ws_ex = 1'b0;
        #1;
        checks++; if (ms_ws.valid !== 1'b0) begin errors++; $display("FAIL flush_after_valid got=%b exp=0", ms_ws.valid); end
        e.dest = 5'd6;
        e.exe_result = 32'h0000_0055;
        issue(e, 32'h0, 1'b1);
        checks++; if (ms_ws.valid !== 1'b1) begin errors++; $display("FAIL flush_next_valid got=%b exp=1", ms_ws.valid); end
        checks++; if (wb.final_result !== 32'h55 || fwd.rf_dest !== 5'd6) begin errors++; $display("FAIL flush_next_data got=%h/%0d exp=00000055/6", wb.final_result, fwd.rf_dest); end
        checks++; if (fwd.fwd_valid !== 4'hf) begin errors++; $display("FAIL flush_next_fwd got=%b exp=1111", fwd.fwd_valid); end
    endtask

    task automatic test_mfc0();
        es_to_ms_bus_t e;
        e = '0;
        e.dest = 5'd8;
        e.cp0_addr = 8'h60;
        e = set_op(e, 8);
        ws_allowin = 1'b1;
        issue(e, 32'h0, 1'b0);
        checks++; if (fwd.blk_valid !== 1'b1) begin errors++; $display("FAIL mfc0_blk got=%b exp=1", fwd.blk_valid); end
        checks++; if (ms_inst_mfc0_o !== 1'b1) begin errors++; $display("FAIL mfc0_o got=%b exp=1", ms_inst_mfc0_o); end
        checks++; if (fwd.fwd_valid !== 4'h0) begin errors++; $display("FAIL mfc0_fwd got=%b exp=0000", fwd.fwd_valid); end
        checks++; if (wb.rf_we !== 4'h0) begin errors++; $display("FAIL mfc0_we got=%b exp=0000", wb.rf_we); end
        eret_flush = 1'b1;
        ws_allowin = 1'b1;
        #1;
        checks++; if (fwd.blk_valid !== 1'b0) begin errors++; $display("FAIL mfc0_eret_blk got=%b exp=0", fwd.blk_valid); end
        checks++; if (ms_ws.valid !== 1'b0) begin errors++; $display("FAIL mfc0_eret_valid got=%b exp=0", ms_ws.valid); end
        @(posedge clk);
        @(negedge clk);
        eret_flush = 1'b0;
        #1;
        checks++; if (ms_ws.valid !== 1'b0) begin errors++; $display("FAIL mfc0_after_valid got=%b exp=0", ms_ws.valid); end
    endtask

    task automatic test_random();
        logic          m_valid;
        logic          m_first;
        es_to_ms_bus_t m_bus;
        logic [31:0]   m_rd;
        logic          flush;
        logic [35:0]   mr;
        ms_to_ws_bus_t x;
        logic          allow;
        m_valid = 1'b0; m_first = 1'b0; m_bus = '0; m_rd = '0;
        @(negedge clk);
        reset = 1'b1; es_valid = 1'b0; ws_ex = 1'b0; eret_flush = 1'b0;
        @(posedge clk);
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            reset = 1'b0;
            flush = ($urandom_range(0, 19) == 0);
            ws_ex = 1'b0;
            eret_flush = 1'b0;
            if (flush) begin
                if ($urandom_range(0, 1) == 1) ws_ex = 1'b1; else eret_flush = 1'b1;
                ws_allowin = 1'b1;
                es_valid   = 1'b0;
            end else begin
                ws_allowin = ($urandom_range(0, 3) != 0);
                es_valid   = ($urandom_range(0, 2) != 0);
            end
            es_bus = rand_bus();
            data_sram_rdata = (m_valid && m_first) ? m_rd : $urandom();
            #1;
            mr = model(m_bus, m_rd);
            checks++; if (es_ms.allowin !== (!m_valid || ws_allowin)) begin errors++; $display("FAIL rnd%0d_allowin got=%b exp=%b", cyc, es_ms.allowin, !m_valid || ws_allowin); end
            checks++; if (ms_ws.valid !== (m_valid && !flush)) begin errors++; $display("FAIL rnd%0d_valid got=%b exp=%b", cyc, ms_ws.valid, m_valid && !flush); end
            checks++; if (ms_ex !== (m_valid && m_bus.ex)) begin errors++; $display("FAIL rnd%0d_ms_ex got=%b exp=%b", cyc, ms_ex, m_valid && m_bus.ex); end
            checks++; if (ms_inst_mfc0_o !== (m_valid && m_bus.mfc0)) begin errors++; $display("FAIL rnd%0d_mfc0 got=%b exp=%b", cyc, ms_inst_mfc0_o, m_valid && m_bus.mfc0); end
            checks++; if (fwd.blk_valid !== (m_valid && m_bus.mfc0 && !flush)) begin errors++; $display("FAIL rnd%0d_blk got=%b exp=%b", cyc, fwd.blk_valid, m_valid && m_bus.mfc0 && !flush); end
            checks++; if (fwd.fwd_valid !== ((m_valid && !m_bus.mfc0 && !flush) ? mr[35:32] : 4'h0))
                begin errors++; $display("FAIL rnd%0d_fwd got=%b exp=%b", cyc, fwd.fwd_valid, (m_valid && !m_bus.mfc0 && !flush) ? mr[35:32] : 4'h0); end
            if (m_valid) begin
                x = '0;
                x.excode = m_bus.excode; x.badvaddr = m_bus.badvaddr; x.cp0_addr = m_bus.cp0_addr;
                x.ex = m_bus.ex; x.bd = m_bus.bd; x.eret = m_bus.eret; x.syscall = m_bus.syscall;
                x.mfc0 = m_bus.mfc0; x.mtc0 = m_bus.mtc0; x.rf_we = mr[35:32]; x.dest = m_bus.dest;
                x.final_result = mr[31:0]; x.pc = m_bus.pc;
                checks++; if (wb !== x) begin errors++; $display("FAIL rnd%0d_bus got=%h exp=%h", cyc, wb, x); end
                checks++; if ({fwd.rf_dest, fwd.rf_data} !== {m_bus.dest, mr[31:0]})
                    begin errors++; $display("FAIL rnd%0d_fwd_data got=%0d/%h exp=%0d/%h", cyc, fwd.rf_dest, fwd.rf_data, m_bus.dest, mr[31:0]); end
            end
            @(posedge clk);
            allow = !m_valid || ws_allowin;
            if (allow) begin
                m_valid = es_valid;
                if (es_valid) begin
                    m_bus   = es_bus;
                    m_rd    = $urandom();
                    m_first = 1'b1;
                end
            end else begin
                m_first = 1'b0;
            end
        end
        @(negedge clk);
        es_valid = 1'b0;
        ws_ex = 1'b0;
        eret_flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_align();
        test_stall();
        test_exception();
        test_flush();
        test_mfc0();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage and upstream of write-back.
- Accepts the execute-to-memory bus and the synchronous data-SRAM read data.
- Extracts and aligns load results for LB/LBU/LH/LHU/LW/LWL/LWR, with per-byte register write enables for LWL/LWR.
- Provides forwarding/blocking info and the exception indication, and passes exception/CP0 fields to write-back.

Parameters:
- None. All widths come from shared header macros: ES_TO_MS_BUS_WD=129, MS_TO_WS_BUS_WD=124, MS_FWD_BLK_BUS_WD=42.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- ws_allowin  in  1  write-back can accept.
- ms_allowin  out  1  MEM can accept.
- es_to_ms_valid  in  1  execute offers an instruction.
- es_to_ms_bus  in  129  fields, MSB first: excode[5], badvaddr[32], cp0_addr[8], ex, bd, eret, syscall, mfc0, mtc0, lb, lbu, lh, lhu, lw, lwl, lwr, res_from_mem, gr_we, dest[5], exe_result[32], pc[32].
- ms_to_ws_valid  out  1  valid toward write-back.
- ms_to_ws_bus  out  124  fields, MSB first: excode[5], badvaddr[32], cp0_addr[8], ex, bd, eret, syscall, mfc0, mtc0, rf_we[4], dest[5], final_result[32], pc[32].
- data_sram_rdata  in  32  read data; valid only the first cycle after the request was issued by execute.
- ms_fwd_blk_bus  out  42  fwd_valid[4] (41:38), rf_dest[5] (37:33), rf_data[32] (32:1), blk_valid (0).
- ms_inst_mfc0_o  out  1  ms_valid & mfc0.
- ms_ex  out  1  ms_valid & bus.ex; execute uses it to suppress stores and HI/LO writes.
- ws_ex  in  1  exception committing in write-back; flushes MEM.
- eret_flush  in  1  ERET committing; flushes MEM.

Behaviour:
- Reset values:
  - ms_valid=0 and rdata_held=0.
  - All outputs gated by ms_valid read 0: ms_to_ws_valid, fwd_valid, ms_ex, ms_inst_mfc0_o.
- Handshake:
  - ms_ready_go=1 (single-cycle stage).
  - ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
  - ms_valid loads es_to_ms_valid when ms_allowin; the bus register loads on es_to_ms_valid & ms_allowin.
- Flush:
  - While ws_ex | eret_flush: ms_to_ws_valid=0, fwd_valid=0, blk_valid=0.
  - ms_valid is overwritten at the next accept; a flushed instruction never reaches write-back.
- Read-data capture (state: EMPTY/HELD, 1 bit rdata_held plus a 32-bit rdata_buf):
  - EMPTY: effective rdata = data_sram_rdata.
  - If ms_valid & !ws_allowin in EMPTY, capture data_sram_rdata into rdata_buf and go to HELD.
  - HELD: effective rdata = rdata_buf; return to EMPTY when ws_allowin, or on a flush.
  - Required so a stalled load keeps correct data after the SRAM output changes.
- Load alignment, with a = exe_result[1:0]:
  - LB/LBU: byte a of rdata, sign-/zero-extended; rf_we=1111.
  - LH/LHU: halfword a[1] of rdata, sign-/zero-extended; rf_we=1111.
  - LW: rdata; rf_we=1111.
  - LWL: result = rdata << (8*(3-a)); rf_we = a0:1000, a1:1100, a2:1110, a3:1111.
  - LWR: result = rdata >> (8*a); rf_we = a0:1111, a1:0111, a2:0011, a3:0001.
  - Non-load: final_result = exe_result; rf_we = {4{gr_we}}.
  - Misaligned LW/LH carry ex=1 from execute; for these, rf_we is forced to 0000.
- rf_we gating: rf_we=0000 whenever bus.ex=1 or the instruction is MFC0 (MFC0 data is produced in write-back).
- Forwarding and blocking:
  - fwd_valid = rf_we & {4{ms_valid & !mfc0}}.
  - rf_dest = dest; rf_data = final_result.
  - blk_valid = ms_valid & mfc0 & !flush.
- Pass-through: badvaddr, excode, cp0_addr, ex, bd, eret, syscall, mtc0 and pc pass unchanged.
- Reset mid-operation: reset asserted while HELD clears both ms_valid and rdata_held.

Decomposition:
- Shared header holds the bus-width macros, the field offsets and the EX_* excodes.
- Sub-module load_align (combinational): inputs op flags, a, rdata; outputs result and rf_we.

Test Plan:
- LB: a=3, rdata=0x80_12_34_56 -> final_result=0xFFFFFF80, rf_we=1111. LBU with the same inputs -> 0x00000080.
- LWL: a=1, rdata=0xAABBCCDD -> result=0xCCDD0000, rf_we=1100. LWR: a=2, same rdata -> result=0x0000AABB, rf_we=0011.
- Stall: LW enters MEM with rdata=0x12345678, ws_allowin=0 for 3 cycles while the SRAM output changes to 0xDEADBEEF -> write-back receives 0x12345678 once ws_allowin=1.
- Exception: es bus ex=1 (excode ADEL, badvaddr 0x1001) -> ms_ex=1 the same cycle, rf_we=0000, fields passed to write-back unchanged.
- Flush: ws_ex=1 while MEM holds a valid ADDU -> ms_to_ws_valid=0, fwd_valid=0. Next instruction is accepted normally.
- MFC0 in MEM -> blk_valid=1, ms_inst_mfc0_o=1, fwd_valid=0000. With eret_flush=1 -> blk_valid=0.
